instr_mem_loader: RTL and testbench

- Parametrised, clocked successor to the fixed combinational instruction ROM.
- Holds DEPTH instruction words of DATA_WIDTH bits and serves a registered read port to the fetch stage with one-cycle latency and a valid strobe.
- Adds a sequential program-load port so firmware can be written word-by-word at run time, plus range checking on both ports.
- Sits between the program loader (UART or bench) and the CPU fetch/decode logic.

---
 rtl/instr_mem_loader.sv | 143 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Brief    : Instruction store with registered fetch port and run-time loader
// Revision : 1.0
// ============================================================================
module instr_mem_loader #(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = 28'h00000AA
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReadEnable,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oValid,
  output logic                  oAddrError,
  input  logic                  iLoadStart,
  input  logic [ADDR_WIDTH-1:0] iLoadBase,
  input  logic [ADDR_WIDTH-1:0] iLoadCount,
  input  logic                  iLoadValid,
  input  logic [DATA_WIDTH-1:0] iLoadData,
  output logic                  oBusy,
  output logic                  oLoadDone,
  output logic                  oLoadError
);

  localparam int                  c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    valid_q, valid_d;
  logic                    aerr_q, aerr_d;
  logic                    done_q, done_d;
  logic                    lerr_q, lerr_d;
  logic                    w_mem_we;
  logic                    w_rd_in_range;
  logic                    w_wr_in_range;

  // Power-up image is all fill words; reset deliberately leaves contents intact.
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH] = '{default: DEFAULT_WORD};

  assign w_rd_in_range = ({1'b0, iAddress} < c_DEPTH);
  assign w_wr_in_range = ({1'b0, ptr_q} < c_DEPTH);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    instr_d  = instr_q;
    valid_d  = 1'b0;
    aerr_d   = 1'b0;
    done_d   = 1'b0;
    lerr_d   = lerr_q;
    w_mem_we = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iLoadStart) begin
          ptr_d  = iLoadBase;
          rem_d  = iLoadCount;
          lerr_d = 1'b0;
          if (iLoadCount == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else if (iReadEnable) begin
          valid_d = 1'b1;
          if (w_rd_in_range) begin
            instr_d = mem_q[iAddress[c_IDX_W-1:0]];
          end else begin
            instr_d = DEFAULT_WORD;
            aerr_d  = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (iLoadValid) begin
          if (w_wr_in_range) begin
            w_mem_we = 1'b1;
          end else begin
            lerr_d = 1'b1;
          end
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == ADDR_WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      instr_q <= DEFAULT_WORD;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (w_mem_we) begin
      mem_q[ptr_q[c_IDX_W-1:0]] <= iLoadData;
    end
  end

  assign oInstruction = instr_q;
  assign oValid       = valid_q;
  assign oAddrError   = aerr_q;
  assign oBusy        = (state_q == ST_LOAD);
  assign oLoadDone    = done_q;
  assign oLoadError   = lerr_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Brief    : Scoreboard bench for instr_mem_loader fetch and load ports
// Revision : 1.0
// ============================================================================
module tb_instr_mem_loader;

  localparam int          c_DW  = 28;
  localparam int          c_AW  = 16;
  localparam int          c_DEP = 256;
  localparam logic [27:0] c_DEF = 28'h00000AA;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic            iReadEnable = 1'b0;
  logic [c_AW-1:0] iAddress = '0;
  logic [c_DW-1:0] oInstruction;
  logic            oValid, oAddrError;
  logic            iLoadStart = 1'b0;
  logic [c_AW-1:0] iLoadBase = '0;
  logic [c_AW-1:0] iLoadCount = '0;
  logic            iLoadValid = 1'b0;
  logic [c_DW-1:0] iLoadData = '0;
  logic            oBusy, oLoadDone, oLoadError;

  typedef struct packed {
    logic        aerr;
    logic [27:0] data;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [27:0] exp_mem [c_DEP];
  int          mptr;
  logic [27:0] last_exp;
  int          n_checks = 0;
  int          n_errors = 0;

  instr_mem_loader #(
    .DATA_WIDTH  (c_DW),
    .ADDR_WIDTH  (c_AW),
    .DEPTH       (c_DEP),
    .DEFAULT_WORD(c_DEF)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .iReadEnable (iReadEnable),
    .iAddress    (iAddress),
    .oInstruction(oInstruction),
    .oValid      (oValid),
    .oAddrError  (oAddrError),
    .iLoadStart  (iLoadStart),
    .iLoadBase   (iLoadBase),
    .iLoadCount  (iLoadCount),
    .iLoadValid  (iLoadValid),
    .iLoadData   (iLoadData),
    .oBusy       (oBusy),
    .oLoadDone   (oLoadDone),
    .oLoadError  (oLoadError)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Read results are retired here as the DUT produces them.
  always @(posedge Clock) begin
    #1;
    if (!Reset && oValid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(oValid), 32'd0);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        chk("rd_data", 32'(oInstruction), 32'(e.data));
        chk("rd_aerr", 32'(oAddrError), 32'(e.aerr));
      end
    end else if (oAddrError) begin
      chk("aerr_without_valid", 32'(oAddrError), 32'd0);
    end
  end

  // All stimulus tasks start and end just after a falling edge.
  task automatic rd(input int a);
    rd_exp_t e;
    iReadEnable = 1'b1;
    iAddress    = c_AW'(a);
    e.aerr = (a >= c_DEP);
    e.data = (a >= c_DEP) ? c_DEF : exp_mem[a];
    last_exp = e.data;
    exp_q.push_back(e);
    @(posedge Clock); #1;
    @(negedge Clock);
    iReadEnable = 1'b0;
  endtask

  task automatic start_load(input int base, input int count);
    iLoadStart = 1'b1;
    iLoadBase  = c_AW'(base);
    iLoadCount = c_AW'(count);
    mptr = base;
    @(posedge Clock); #1;
    chk("start_busy", 32'(oBusy), 32'(count != 0));
    chk("start_lerr_clr", 32'(oLoadError), 32'd0);
    chk("start_done", 32'(oLoadDone), 32'(count == 0));
    @(negedge Clock);
    iLoadStart = 1'b0;
  endtask

  task automatic push_word(input logic [27:0] d, input bit last);
    iLoadValid = 1'b1;
    iLoadData  = d;
    @(posedge Clock); #1;
    if (mptr < c_DEP) exp_mem[mptr] = d;
    mptr = (mptr + 1) % 65536;
    chk("word_done", 32'(oLoadDone), 32'(last));
    chk("word_busy", 32'(oBusy), 32'(!last));
    @(negedge Clock);
    iLoadValid = 1'b0;
  endtask

  task automatic stall;
    @(posedge Clock); #1;
    chk("stall_busy", 32'(oBusy), 32'd1);
    chk("stall_done", 32'(oLoadDone), 32'd0);
    @(negedge Clock);
  endtask

  initial begin
    for (int i = 0; i < c_DEP; i++) exp_mem[i] = c_DEF;
    last_exp = c_DEF;
    repeat (2) @(negedge Clock);
    chk("rst_instr", 32'(oInstruction), 32'(c_DEF));
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_aerr", 32'(oAddrError), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oLoadDone), 32'd0);
    chk("rst_lerr", 32'(oLoadError), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    // Back-to-back reads of unwritten locations.
    rd(0);
    rd(5);
    @(negedge Clock);

    // Load with one stall, then read-after-write.
    start_load(3, 3);
    push_word(28'h1000001, 1'b0);
    push_word(28'h1000002, 1'b0);
    stall();
    push_word(28'h1000003, 1'b1);
    rd(3);
    rd(4);
    rd(5);
    rd(6);
    rd(4);
    repeat (2) @(negedge Clock);
    chk("instr_hold", 32'(oInstruction), 32'(last_exp));
    chk("valid_low_idle", 32'(oValid), 32'd0);

    // Out-of-range read.
    rd(300);
    @(posedge Clock); #1;
    chk("aerr_one_cycle", 32'(oAddrError), 32'd0);
    @(negedge Clock);

    // Load running off the end of the array.
    start_load(254, 4);
    push_word(28'h2000001, 1'b0);
    push_word(28'h2000002, 1'b0);
    push_word(28'h2000003, 1'b0);
    push_word(28'h2000004, 1'b1);
    chk("lerr_sticky", 32'(oLoadError), 32'd1);
    rd(254);
    rd(255);
    rd(0);
    @(negedge Clock);
    chk("lerr_still_set", 32'(oLoadError), 32'd1);

    // Read collides with load start; reads held during LOAD are dropped;
    // a second start during LOAD is ignored.
    iReadEnable = 1'b1;
    iAddress    = 16'd3;
    start_load(10, 2);
    iReadEnable = 1'b1;
    push_word(28'h3000001, 1'b0);
    iReadEnable = 1'b1;
    iLoadStart  = 1'b1;
    iLoadBase   = 16'd100;
    iLoadCount  = 16'd50;
    stall();
    iLoadStart  = 1'b0;
    push_word(28'h3000002, 1'b1);
    iReadEnable = 1'b0;
    rd(10);
    rd(11);
    rd(100);
    @(negedge Clock);

    // Zero-length load.
    start_load(40, 0);
    @(posedge Clock); #1;
    chk("zero_done_once", 32'(oLoadDone), 32'd0);
    chk("zero_busy", 32'(oBusy), 32'd0);
    @(negedge Clock);

    // Reset in the middle of a load.
    start_load(20, 4);
    push_word(28'h4000001, 1'b0);
    push_word(28'h4000002, 1'b0);
    #2 Reset = 1'b1;
    #1;
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_done", 32'(oLoadDone), 32'd0);
    chk("abort_instr", 32'(oInstruction), 32'(c_DEF));
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    rd(20);
    rd(21);
    rd(22);
    rd(23);
    rd(3);
    repeat (3) @(negedge Clock);
    chk("abort_no_done", 32'(oLoadDone), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
